// File: rtl/upme_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : upme_seq_pkg
// Brief    : Shared constants for the upme run controller.
// Revision : 1.0 - initial release
// ============================================================================
package upme_seq_pkg;

    localparam logic [1:0] MODE_UP    = 2'b00;
    localparam logic [1:0] MODE_DN    = 2'b01;
    localparam logic [1:0] MODE_PP    = 2'b10;
    localparam logic [1:0] MODE_SWEEP = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [2:0] EA_MAX = 3'd7;
    localparam logic [2:0] EA_MIN = 3'd0;

endpackage
`default_nettype wire

// File: rtl/upme_seq_presc.sv
`default_nettype none
// ============================================================================
// Module   : seq_presc
// Brief    : Tick prescaler with clear, hold (enable) and wrap pulse.
// Revision : 1.0 - initial release
// ============================================================================
module seq_presc #(
    parameter int DIV_W = 4,
    parameter int DIV   = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic wrap
);

    localparam logic [DIV_W-1:0] c_last = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0] c_one  = {{(DIV_W-1){1'b0}}, 1'b1};

    logic [DIV_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap = en && (r_cnt == c_last);
    assign wrap   = w_wrap;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr || w_wrap) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= r_cnt + c_one;
        end
    end

endmodule
`default_nettype wire

// File: rtl/upme_seq.sv
`default_nettype none
// ============================================================================
// Module   : upme_seq
// Brief    : Run controller for the upme up/down counter (tick, direction).
// Revision : 1.0 - initial release
// ============================================================================
module upme_seq
    import upme_seq_pkg::*;
#(
    parameter int DIV_W = 4,
    parameter int DIV   = 10
) (
    input  logic       eck,
    input  logic       er,
    input  logic       start,
    input  logic       stop,
    input  logic       hold,
    input  logic [1:0] mode,
    input  logic [3:0] nsteps,
    input  logic [2:0] ea,
    output logic       up,
    output logic       tick,
    output logic       busy,
    output logic       done
);

    logic [1:0] r_state;
    logic [1:0] r_mode;
    logic [3:0] r_steps;
    logic       r_up;
    logic       r_tick;
    logic       r_busy;
    logic       r_done;

    logic       w_run;
    logic       w_wrap;
    logic       w_sweep_end;
    logic       w_counted;
    logic       w_last;

    assign w_run       = (r_state == ST_RUN);
    assign w_sweep_end = (r_mode == MODE_SWEEP) && (ea == EA_MAX);
    assign w_counted   = (r_mode != MODE_SWEEP) && (r_steps != 4'd0);
    assign w_last      = w_counted && (r_steps == 4'd1);

    // Prescaler is held at zero outside RUN so every run starts a full period.
    seq_presc #(
        .DIV_W (DIV_W),
        .DIV   (DIV)
    ) u_presc (
        .clk   (eck),
        .rst_n (er),
        .clr   (!w_run),
        .en    (w_run && !hold && !stop),
        .wrap  (w_wrap)
    );

    always_ff @(posedge eck) begin
        if (!er) begin
            r_state <= ST_IDLE;
            r_mode  <= MODE_UP;
            r_steps <= 4'd0;
            r_up    <= 1'b1;
            r_tick  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start && !stop) begin
                        r_state <= ST_RUN;
                        r_mode  <= mode;
                        r_steps <= nsteps;
                        r_up    <= (mode != MODE_DN);
                        r_busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_sweep_end) begin
                        r_state <= ST_DONE;
                    end else begin
                        if (w_wrap) begin
                            r_tick <= 1'b1;
                            if (w_counted) begin
                                r_steps <= r_steps - 4'd1;
                            end
                            if (w_last) begin
                                r_state <= ST_DONE;
                            end
                        end
                        // Reversal tracks the counter's reported position, also while held.
                        if (r_mode == MODE_PP) begin
                            if (r_up && (ea == EA_MAX)) begin
                                r_up <= 1'b0;
                            end else if (!r_up && (ea == EA_MIN)) begin
                                r_up <= 1'b1;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign up   = r_up;
    assign tick = r_tick;
    assign busy = r_busy;
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_upme_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_upme_seq
// Brief    : Directed self-checking bench for upme_seq with a upme counter model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_upme_seq;

    logic       eck    = 1'b0;
    logic       er     = 1'b0;
    logic       start  = 1'b0;
    logic       stop   = 1'b0;
    logic       hold   = 1'b0;
    logic [1:0] mode   = 2'b00;
    logic [3:0] nsteps = 4'd0;
    logic [2:0] ea;
    logic       up;
    logic       tick;
    logic       busy;
    logic       done;

    logic       ea_set = 1'b0;
    logic [2:0] ea_val = 3'd0;

    int checks = 0;
    int errors = 0;

    upme_seq #(
        .DIV_W (4),
        .DIV   (10)
    ) dut (
        .eck    (eck),
        .er     (er),
        .start  (start),
        .stop   (stop),
        .hold   (hold),
        .mode   (mode),
        .nsteps (nsteps),
        .ea     (ea),
        .up     (up),
        .tick   (tick),
        .busy   (busy),
        .done   (done)
    );

    always #5 eck = ~eck;

    // upme counter model: state moves one cycle after tick
    always @(posedge eck) begin
        if (ea_set)
            ea <= ea_val;
        else if (tick)
            ea <= up ? ea + 3'd1 : ea - 3'd1;
    end

    task automatic step();
        @(posedge eck);
        #1;
    endtask

    task automatic preset_ea(input logic [2:0] v);
        ea_val = v;
        ea_set = 1'b1;
        step();
        ea_set = 1'b0;
    endtask

    task automatic begin_run(input logic [1:0] m, input logic [3:0] n);
        mode   = m;
        nsteps = n;
        start  = 1'b1;
        step();
        start  = 1'b0;
    endtask

    task automatic test_reset();
        er = 1'b0;
        preset_ea(3'd0);
        step();
        checks++; if (up !== 1'b1) begin errors++; $display("FAIL reset_up got %b exp 1", up); end
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b exp 0", tick); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        er = 1'b1;
        step();
    endtask

    task automatic test_mode_up();
        logic exp_tick, exp_done, exp_busy;
        preset_ea(3'd0);
        begin_run(2'b00, 4'd3);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL up_busy_rise got %b exp 1", busy); end
        for (int k = 1; k <= 35; k++) begin
            step();
            exp_tick = (k == 10) || (k == 20) || (k == 30);
            exp_done = (k == 31);
            exp_busy = (k <= 30);
            checks++; if (tick !== exp_tick) begin errors++; $display("FAIL up_tick k=%0d got %b exp %b", k, tick, exp_tick); end
            checks++; if (done !== exp_done) begin errors++; $display("FAIL up_done k=%0d got %b exp %b", k, done, exp_done); end
            checks++; if (busy !== exp_busy) begin errors++; $display("FAIL up_busy k=%0d got %b exp %b", k, busy, exp_busy); end
        end
        checks++; if (ea !== 3'd3) begin errors++; $display("FAIL up_ea_end got %0d exp 3", ea); end
    endtask

    task automatic test_reset_midrun();
        logic exp_tick, exp_done;
        preset_ea(3'd2);
        begin_run(2'b01, 4'd0);
        checks++; if (up !== 1'b0) begin errors++; $display("FAIL dn_up_start got %b exp 0", up); end
        repeat (5) step();
        er = 1'b0;
        step();
        er = 1'b1;
        checks++; if (up !== 1'b1) begin errors++; $display("FAIL midrst_up got %b exp 1", up); end
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL midrst_tick got %b exp 0", tick); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", busy); end
        repeat (12) step();
        checks++; if (busy !== 1'b0 || tick !== 1'b0) begin errors++; $display("FAIL midrst_idle got busy=%b tick=%b exp 0/0", busy, tick); end
        begin_run(2'b00, 4'd1);
        for (int k = 1; k <= 12; k++) begin
            step();
            exp_tick = (k == 10);
            exp_done = (k == 11);
            checks++; if (tick !== exp_tick) begin errors++; $display("FAIL postrst_tick k=%0d got %b exp %b", k, tick, exp_tick); end
            checks++; if (done !== exp_done) begin errors++; $display("FAIL postrst_done k=%0d got %b exp %b", k, done, exp_done); end
        end
    endtask

    task automatic test_pingpong();
        logic exp_tick, exp_up;
        preset_ea(3'd5);
        begin_run(2'b10, 4'd0);
        for (int k = 1; k <= 105; k++) begin
            step();
            exp_tick = ((k % 10) == 0);
            exp_up   = !((k >= 22) && (k < 92));
            checks++; if (tick !== exp_tick) begin errors++; $display("FAIL pp_tick k=%0d got %b exp %b", k, tick, exp_tick); end
            checks++; if (up !== exp_up) begin errors++; $display("FAIL pp_up k=%0d got %b exp %b", k, up, exp_up); end
            if (k == 21) begin
                checks++; if (ea !== 3'd7) begin errors++; $display("FAIL pp_ea_top got %0d exp 7", ea); end
            end
            if (k == 91) begin
                checks++; if (ea !== 3'd0) begin errors++; $display("FAIL pp_ea_bottom got %0d exp 0", ea); end
            end
            if (k == 101) begin
                checks++; if (ea !== 3'd1) begin errors++; $display("FAIL pp_ea_after got %0d exp 1", ea); end
            end
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pp_stop_busy got %b exp 0", busy); end
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL pp_stop_tick got %b exp 0", tick); end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL pp_stop_done got %b exp 0", done); end
        end
    endtask

    task automatic test_sweep();
        logic exp_tick, exp_done, exp_busy;
        preset_ea(3'd4);
        begin_run(2'b11, 4'd5);
        for (int k = 1; k <= 36; k++) begin
            step();
            exp_tick = (k == 10) || (k == 20) || (k == 30);
            exp_done = (k == 33);
            exp_busy = (k <= 32);
            checks++; if (tick !== exp_tick) begin errors++; $display("FAIL sw_tick k=%0d got %b exp %b", k, tick, exp_tick); end
            checks++; if (done !== exp_done) begin errors++; $display("FAIL sw_done k=%0d got %b exp %b", k, done, exp_done); end
            checks++; if (busy !== exp_busy) begin errors++; $display("FAIL sw_busy k=%0d got %b exp %b", k, busy, exp_busy); end
        end
        checks++; if (ea !== 3'd7) begin errors++; $display("FAIL sw_ea_end got %0d exp 7", ea); end
    endtask

    task automatic test_sweep_at_max();
        logic exp_done;
        preset_ea(3'd7);
        begin_run(2'b11, 4'd0);
        for (int k = 1; k <= 4; k++) begin
            step();
            exp_done = (k == 2);
            checks++; if (tick !== 1'b0) begin errors++; $display("FAIL swmax_tick k=%0d got %b exp 0", k, tick); end
            checks++; if (done !== exp_done) begin errors++; $display("FAIL swmax_done k=%0d got %b exp %b", k, done, exp_done); end
        end
    endtask

    task automatic test_stop_final();
        preset_ea(3'd0);
        begin_run(2'b00, 4'd1);
        repeat (9) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL stopfin_tick got %b exp 0", tick); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stopfin_busy got %b exp 0", busy); end
        step();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL stopfin_done got %b exp 0", done); end
        checks++; if (ea !== 3'd0) begin errors++; $display("FAIL stopfin_ea got %0d exp 0", ea); end
    endtask

    task automatic test_start_stop_idle();
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ss_busy got %b exp 0", busy); end
        repeat (12) step();
        checks++; if (tick !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ss_idle got busy=%b tick=%b exp 0/0", busy, tick); end
    endtask

    task automatic test_back_to_back_start();
        logic exp_tick, exp_done;
        preset_ea(3'd0);
        begin_run(2'b00, 4'd2);
        for (int k = 1; k <= 24; k++) begin
            step();
            exp_tick = (k == 10) || (k == 20);
            exp_done = (k == 21);
            checks++; if (tick !== exp_tick) begin errors++; $display("FAIL b2b_tick k=%0d got %b exp %b", k, tick, exp_tick); end
            checks++; if (done !== exp_done) begin errors++; $display("FAIL b2b_done k=%0d got %b exp %b", k, done, exp_done); end
            checks++; if (up !== 1'b1) begin errors++; $display("FAIL b2b_up k=%0d got %b exp 1", k, up); end
            start  = (k == 5);
            mode   = (k == 5) ? 2'b01 : 2'b00;
            nsteps = (k == 5) ? 4'd9 : 4'd2;
        end
        checks++; if (ea !== 3'd2) begin errors++; $display("FAIL b2b_ea got %0d exp 2", ea); end
    endtask

    task automatic test_hold();
        logic exp_tick, exp_done;
        preset_ea(3'd0);
        begin_run(2'b00, 4'd2);
        for (int k = 1; k <= 28; k++) begin
            step();
            exp_tick = (k == 14) || (k == 24);
            exp_done = (k == 25);
            checks++; if (tick !== exp_tick) begin errors++; $display("FAIL hold_tick k=%0d got %b exp %b", k, tick, exp_tick); end
            checks++; if (done !== exp_done) begin errors++; $display("FAIL hold_done k=%0d got %b exp %b", k, done, exp_done); end
            hold = (k >= 2) && (k <= 5);
        end
        hold = 1'b0;
    endtask

    initial begin
        test_reset();
        test_mode_up();
        test_reset_midrun();
        test_pingpong();
        test_sweep();
        test_sweep_at_max();
        test_stop_final();
        test_start_stop_idle();
        test_back_to_back_start();
        test_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/upme_seq.md
# upme_seq

Run controller for the `upme` up/down state counter. Sequences the counter:
- drives its direction input `up` and its count-enable (`high`) with a single-cycle `tick`;
- supports fixed-step runs, up-only, down-only, ping-pong and single-sweep modes;
- monitors the 3-bit state feedback `ea`, so direction reversal and sweep termination follow the counter's actual position.

## Interface
Parameters:
- `DIV_W`, 4: prescaler counter width.
- `DIV`, 10: clock cycles per `tick` while running; legal range 2..2^DIV_W.

Ports:
- `eck` in 1: clock, all logic on rising edge.
- `er` in 1: reset, synchronous, active-low.
- `start` in 1: begin a run (sampled in IDLE only).
- `stop` in 1: abort the run; has priority over everything except reset.
- `hold` in 1: freeze the prescaler and step count while high.
- `mode` in 2: 00 up-only, 01 down-only, 10 ping-pong, 11 single sweep; latched at start.
- `nsteps` in 4: ticks per run; 0 = continuous until `stop` (ignored in mode 11).
- `ea` in 3: current counter state fed back from `upme` (`oea[2:0]`).
- `up` out 1: direction to counter (1 = increment).
- `tick` out 1: one-cycle count-enable to counter.
- `busy` out 1: high in RUN.
- `done` out 1: one-cycle pulse on normal completion.

## Operation
- States: IDLE, RUN, DONE.
- Reset (`er`=0 at an edge) forces the following, including mid-run:
  - state IDLE;
  - `up`=1, `tick`=0, `busy`=0, `done`=0;
  - prescaler = 0, step count = 0.
- IDLE → RUN on `start`=1 and `stop`=0. On that edge:
  - latch `mode`;
  - load step count with `nsteps`;
  - prescaler = 0;
  - `up` = 0 if mode 01, else 1.
- In IDLE, `start` and `stop` both high: stay in IDLE.
- RUN, per cycle, with `hold`=0:
  - Prescaler increments.
  - When the prescaler equals DIV-1: `tick`=1 that cycle, prescaler wraps to 0, and the step count decrements if nonzero-mode.
- `hold`=1 in RUN: `tick`=0; prescaler and step count frozen; direction logic still active.
- Direction in ping-pong (mode 10), evaluated every RUN cycle:
  - `up`=1 and `ea`=7 → `up`=0 next cycle;
  - `up`=0 and `ea`=0 → `up`=1 next cycle.
- Modes 00/01 never change `up`; the counter wraps 7→0 / 0→7 as the counter itself defines.
- Completion:
  - Modes 00–10 with `nsteps`≠0: the tick that brings the step count to 0 goes RUN → DONE.
  - Mode 11: the first RUN cycle with `ea`=7 goes RUN → DONE, with no further tick. If `ea`=7 already at start, DONE follows after one RUN cycle with no tick.
- DONE: `done`=1 for exactly one cycle, `busy`=0, then IDLE. `up` keeps its last value until the next start.
- `stop`=1 in RUN: next state IDLE; `tick` forced 0 that cycle; no `done`.
  - If `stop` coincides with the final tick, the tick is suppressed and `done` is not pulsed.
- `start` during RUN/DONE: ignored.
- Mode/`nsteps` changes during RUN: no effect.

## Timing
- `tick`, `up`, `busy` and `done` are registered outputs.
- First `tick` is DIV cycles after the start edge.
- Ticks are then every DIV cycles, stretched by held cycles.
- `upme` state updates one cycle after `tick`. `ea` is therefore valid ≥1 cycle before the next tick, since DIV ≥ 2, so a reversal always precedes the next tick.
- `done` asserts the cycle after the final tick.
- `busy` rises the cycle after `start` and falls on the DONE/IDLE transition.

## Structure
- Package `upme_seq_pkg`: mode constants (MODE_UP, MODE_DN, MODE_PP, MODE_SWEEP), state enum/encoding (IDLE, RUN, DONE), EA_MAX=3'd7, EA_MIN=3'd0.
- Sub-module `seq_presc`: parameterized DIV_W/DIV prescaler with clear, hold and wrap-pulse output. Reused by the FSM top.
- Top holds the FSM, step counter and direction register.

## Test plan
- Reset mid-run: `er`=0 while RUN with prescaler at 5 → next cycle IDLE, `up`=1, `tick`=0, `busy`=0, prescaler 0.
- Mode 00, `nsteps`=3, DIV=10, counter model at 0:
  - ticks at cycles 10, 20, 30 after start;
  - `ea` ends at 3;
  - `done` pulse at cycle 31, then IDLE.
- Mode 10, continuous, `ea` from 5:
  - sequence 6, 7, 6, …, 0, 1;
  - `up` drops one cycle after `ea`=7 and rises one cycle after `ea`=0;
  - no tick lost; `stop` ends the run without `done`.
- Mode 11 from `ea`=4: exactly 3 ticks; `done` one cycle after `ea`=7 is seen.
- Simultaneous events:
  - `stop` on the final-tick cycle → no tick, no `done`, IDLE;
  - `start`+`stop` in IDLE → stays IDLE;
  - `start` during RUN → ignored.
- `hold`: asserted 4 cycles mid-period with DIV=10 → that tick delayed by exactly 4 cycles; step count unchanged during hold.
